// File: rtl/exec_imm_arith.sv
// exec_imm_arith: I-type integer ALU stage (ADDI/SLTI/SLTIU/XORI/ORI/ANDI/
// SLLI/SRLI/SRAI) with a one-entry result register and valid/ready handshakes.
// Optional macro EXEC_IMM_ARITH_SERIAL_SHIFT_EN replaces the barrel shifter
// with a one-bit-per-cycle shifter (FSM state SHIFT); results are identical.

package exec_imm_arith_pkg;
  typedef enum logic [3:0] {
    iak_addi,
    iak_slti,
    iak_sltiu,
    iak_xori,
    iak_ori,
    iak_andi,
    iak_slli,
    iak_srli,
    iak_srai,
    iak_invalid
  } imm_arith_kind_t;
endpackage

module exec_imm_arith
  import exec_imm_arith_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  imm_arith_kind_t kind,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [11:0]     imm,
  input  logic [4:0]      rd_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t          state_reg;
  logic            out_valid_reg;
  logic [XLEN-1:0] out_data_reg;
  logic [4:0]      out_rd_reg;
  logic            out_illegal_reg;

  logic [XLEN-1:0] simm;
  logic [4:0]      shamt;
  logic [XLEN-1:0] result_comb;
  logic            accept;

  assign simm  = {{(XLEN-12){imm[11]}}, imm};
  assign shamt = imm[4:0];

  // A new instruction is taken only when idle and the result slot is free or
  // being drained on this very edge; reset forces the handshake closed.
  assign in_ready = !rst && (state_reg == ST_IDLE) && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;

  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign out_rd      = out_rd_reg;
  assign out_illegal = out_illegal_reg;

`ifdef EXEC_IMM_ARITH_SERIAL_SHIFT_EN
  logic [XLEN-1:0] op_reg;
  logic [4:0]      cnt_reg;
  imm_arith_kind_t shift_kind_reg;
  logic            is_shift;

  assign is_shift = (kind == iak_slli) || (kind == iak_srli) || (kind == iak_srai);

  // One step of the serial shifter for the captured shift kind.
  function automatic logic [XLEN-1:0] shift_one(input imm_arith_kind_t k,
                                                input logic [XLEN-1:0] v);
    case (k)
      iak_slli: shift_one = {v[XLEN-2:0], 1'b0};
      iak_srli: shift_one = {1'b0, v[XLEN-1:1]};
      default:  shift_one = {v[XLEN-1], v[XLEN-1:1]};
    endcase
  endfunction
`endif

  // Single-cycle result for every kind that completes on acceptance.
  always_comb begin
    result_comb = '0;
    case (kind)
      iak_addi:  result_comb = rs1_val + simm;
      iak_slti:  result_comb = {{(XLEN-1){1'b0}}, ($signed(rs1_val) < $signed(simm))};
      iak_sltiu: result_comb = {{(XLEN-1){1'b0}}, (rs1_val < simm)};
      iak_xori:  result_comb = rs1_val ^ simm;
      iak_ori:   result_comb = rs1_val | simm;
      iak_andi:  result_comb = rs1_val & simm;
`ifdef EXEC_IMM_ARITH_SERIAL_SHIFT_EN
      // Only shamt == 0 shifts take this path; they return rs1 unchanged.
      iak_slli,
      iak_srli,
      iak_srai:  result_comb = rs1_val;
`else
      iak_slli:  result_comb = rs1_val << shamt;
      iak_srli:  result_comb = rs1_val >> shamt;
      iak_srai:  result_comb = $unsigned($signed(rs1_val) >>> shamt);
`endif
      default:   result_comb = '0;
    endcase
  end

  // Handshake FSM, result register and (optionally) the serial shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      out_valid_reg   <= 1'b0;
      out_data_reg    <= '0;
      out_rd_reg      <= '0;
      out_illegal_reg <= 1'b0;
`ifdef EXEC_IMM_ARITH_SERIAL_SHIFT_EN
      op_reg          <= '0;
      cnt_reg         <= '0;
      shift_kind_reg  <= iak_slli;
`endif
    end else begin
      if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
      if (accept) begin
        out_rd_reg <= rd_addr;
`ifdef EXEC_IMM_ARITH_SERIAL_SHIFT_EN
        if (is_shift && (shamt != 5'd0)) begin
          state_reg      <= ST_SHIFT;
          op_reg         <= rs1_val;
          cnt_reg        <= shamt;
          shift_kind_reg <= kind;
        end else begin
          out_data_reg    <= result_comb;
          out_illegal_reg <= (kind == iak_invalid);
          out_valid_reg   <= 1'b1;
        end
`else
        out_data_reg    <= result_comb;
        out_illegal_reg <= (kind == iak_invalid);
        out_valid_reg   <= 1'b1;
`endif
      end
`ifdef EXEC_IMM_ARITH_SERIAL_SHIFT_EN
      // The edge that sees counter == 1 performs the last bit and publishes.
      if (state_reg == ST_SHIFT) begin
        op_reg  <= shift_one(shift_kind_reg, op_reg);
        cnt_reg <= cnt_reg - 5'd1;
        if (cnt_reg == 5'd1) begin
          out_data_reg    <= shift_one(shift_kind_reg, op_reg);
          out_illegal_reg <= 1'b0;
          out_valid_reg   <= 1'b1;
          state_reg       <= ST_IDLE;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_exec_imm_arith.sv
// Self-checking bench for exec_imm_arith: directed vector table, random
// operations against an arithmetic reference model, backpressure and reset
// sequences. Works with and without EXEC_IMM_ARITH_SERIAL_SHIFT_EN.

module tb_exec_imm_arith;
  import exec_imm_arith_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  imm_arith_kind_t kind;
  logic [31:0]     rs1_val;
  logic [11:0]     imm;
  logic [4:0]      rd_addr;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_data;
  logic [4:0]      out_rd;
  logic            out_illegal;

  int total = 0;
  int bad   = 0;

  exec_imm_arith #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .kind       (kind),
    .rs1_val    (rs1_val),
    .imm        (imm),
    .rd_addr    (rd_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_rd     (out_rd),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    imm_arith_kind_t k;
    logic [31:0]     a;
    logic [11:0]     im;
    logic [4:0]      rd;
    logic [31:0]     exp_d;
    logic            exp_ill;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: rules of the ISA with plain integer arithmetic.
  function automatic logic [32:0] ref_calc(input imm_arith_kind_t k, input logic [31:0] a,
                                           input logic [11:0] im);
    longint s, p, x;
    logic [31:0] su, r;
    logic ill;
    s   = im[11] ? longint'(im) - 4096 : longint'(im);
    su  = 32'(s);
    p   = 1;
    for (int i = 0; i < int'(im[4:0]); i++) p = p * 2;
    x   = longint'(signed'(a));
    ill = 1'b0;
    case (k)
      iak_addi:  r = 32'(longint'(a) + s);
      iak_slti:  r = (x < s) ? 32'd1 : 32'd0;
      iak_sltiu: r = (a < su) ? 32'd1 : 32'd0;
      iak_xori:  r = a ^ su;
      iak_ori:   r = a | su;
      iak_andi:  r = a & su;
      iak_slli:  r = 32'(longint'(a) * p);
      iak_srli:  r = 32'(longint'(a) / p);
      iak_srai:  r = (x >= 0) ? 32'(x / p) : 32'(-((-x - 1) / p) - 1);
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
    return {ill, r};
  endfunction

  // Cycles spent in the serial shifter after acceptance (0 = result next cycle).
  function automatic int exp_busy(input imm_arith_kind_t k, input logic [11:0] im);
`ifdef EXEC_IMM_ARITH_SERIAL_SHIFT_EN
    if ((k == iak_slli || k == iak_srli || k == iak_srai) && im[4:0] != 5'd0)
      return int'(im[4:0]);
`endif
    return 0;
  endfunction

  // Issue one instruction (entered at a negedge) and check its result.
  task automatic run_op(input string name, input imm_arith_kind_t k, input logic [31:0] a,
                        input logic [11:0] im, input logic [4:0] rd,
                        input logic [31:0] exp_d, input logic exp_ill);
    int n;
    int busy;
    logic ready_seen;
    in_valid  = 1'b1;
    kind      = k;
    rs1_val   = a;
    imm       = im;
    rd_addr   = rd;
    out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, " accept"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    busy       = 0;
    ready_seen = 1'b0;
    while (!out_valid && busy < 40) begin
      if (in_ready) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      busy++;
    end
    check({name, " valid"}, {31'd0, out_valid}, 32'd1);
    check({name, " busy_cycles"}, busy, exp_busy(k, im));
    check({name, " ready_in_shift"}, {31'd0, ready_seen}, 32'd0);
    check({name, " data"}, out_data, exp_d);
    check({name, " rd"}, {27'd0, out_rd}, {27'd0, rd});
    check({name, " illegal"}, {31'd0, out_illegal}, {31'd0, exp_ill});
    $display("op %-8s kind=%0d rs1=%h imm=%h -> data=%h rd=%0d ill=%0b busy=%0d",
             name, k, a, im, out_data, out_rd, out_illegal, busy);
    @(negedge clk);
  endtask

  vec_t vecs[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] r;
    imm_arith_kind_t rk;
    logic [31:0] ra;
    logic [11:0] ri;
    logic [31:0] held;

    vecs[0]  = '{iak_addi,    32'h0000_0005, 12'hFFF, 5'd9,  32'h0000_0004, 1'b0};
    vecs[1]  = '{iak_slti,    32'hFFFF_FFFF, 12'h001, 5'd1,  32'h0000_0001, 1'b0};
    vecs[2]  = '{iak_sltiu,   32'hFFFF_FFFF, 12'h001, 5'd2,  32'h0000_0000, 1'b0};
    vecs[3]  = '{iak_sltiu,   32'h0000_0000, 12'hFFF, 5'd3,  32'h0000_0001, 1'b0};
    vecs[4]  = '{iak_srai,    32'h8000_0000, 12'h41F, 5'd4,  32'hFFFF_FFFF, 1'b0};
    vecs[5]  = '{iak_srli,    32'h8000_0000, 12'h01F, 5'd5,  32'h0000_0001, 1'b0};
    vecs[6]  = '{iak_invalid, 32'h1234_5678, 12'hABC, 5'd6,  32'h0000_0000, 1'b1};
    vecs[7]  = '{iak_ori,     32'h0000_F000, 12'h0F0, 5'd7,  32'h0000_F0F0, 1'b0};
    vecs[8]  = '{iak_xori,    32'hAAAA_5555, 12'hFFF, 5'd8,  32'h5555_AAAA, 1'b0};
    vecs[9]  = '{iak_andi,    32'h1234_5678, 12'h0FF, 5'd10, 32'h0000_0078, 1'b0};
    vecs[10] = '{iak_slli,    32'h0000_0001, 12'h01F, 5'd11, 32'h8000_0000, 1'b0};
    vecs[11] = '{iak_slli,    32'hDEAD_BEEF, 12'h000, 5'd12, 32'hDEAD_BEEF, 1'b0};
    vecs[12] = '{iak_addi,    32'h7FFF_FFFF, 12'h001, 5'd13, 32'h8000_0000, 1'b0};
    vecs[13] = '{iak_srai,    32'h8000_0000, 12'h401, 5'd31, 32'hC000_0000, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    kind      = iak_addi;
    rs1_val   = '0;
    imm       = '0;
    rd_addr   = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_data", out_data, 32'd0);
    check("rst out_rd", {27'd0, out_rd}, 32'd0);
    check("rst out_illegal", {31'd0, out_illegal}, 32'd0);
    rst = 1'b0;
    // out_ready toggling with nothing held must not create a result
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    check("idle out_valid", {31'd0, out_valid}, 32'd0);
    check("idle in_ready", {31'd0, in_ready}, 32'd1);

    // Directed vectors
    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), vecs[i].k, vecs[i].a, vecs[i].im, vecs[i].rd,
             vecs[i].exp_d, vecs[i].exp_ill);

    // Drain the last result, then check out_valid falls
    @(posedge clk);
    #1;
    check("drain out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);

    // Backpressure: A held, B waiting for three cycles
    in_valid  = 1'b1;
    kind      = iak_addi;
    rs1_val   = 32'd100;
    imm       = 12'h007;
    rd_addr   = 5'd3;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    kind    = iak_ori;
    rs1_val = 32'h0000_00F0;
    imm     = 12'h00F;
    rd_addr = 5'd4;
    held    = out_data;
    check("bp A data", out_data, 32'd107);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("bp%0d in_ready", c), {31'd0, in_ready}, 32'd0);
      check($sformatf("bp%0d valid", c), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp%0d data", c), out_data, held);
      check($sformatf("bp%0d rd", c), {27'd0, out_rd}, 32'd3);
      $display("bp cycle %0d in_ready=%0b data=%h rd=%0d", c, in_ready, out_data, out_rd);
    end
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp B valid", {31'd0, out_valid}, 32'd1);
    check("bp B data", out_data, 32'h0000_00FF);
    check("bp B rd", {27'd0, out_rd}, 32'd4);
    @(posedge clk);
    #1;
    check("bp after drain valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);

    // Asynchronous reset while a result is held
    in_valid  = 1'b1;
    kind      = iak_addi;
    rs1_val   = 32'h55;
    imm       = 12'h001;
    rd_addr   = 5'd17;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("hold before rst", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst valid", {31'd0, out_valid}, 32'd0);
    check("async rst data", out_data, 32'd0);
    check("async rst rd", {27'd0, out_rd}, 32'd0);
    check("async rst in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

`ifdef EXEC_IMM_ARITH_SERIAL_SHIFT_EN
    // Reset in the middle of a serial SLLI abandons it
    in_valid = 1'b1;
    kind     = iak_slli;
    rs1_val  = 32'h0000_0003;
    imm      = 12'h00A;
    rd_addr  = 5'd21;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("shift in_ready busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("shift rst valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("shift rst in_ready", {31'd0, in_ready}, 32'd1);
    repeat (15) @(posedge clk);
    #1;
    check("shift abandoned", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
`endif

    // Random operations against the reference model
    for (int i = 0; i < 80; i++) begin
      rk = imm_arith_kind_t'($urandom_range(0, 9));
      ra = $urandom;
      ri = 12'($urandom);
      r  = ref_calc(rk, ra, ri);
      run_op($sformatf("rnd%0d", i), rk, ra, ri, 5'($urandom), r[31:0], r[32]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
